// File: rtl/elm_layer_sequencer_pkg.sv
// Shared definitions for the ELM hidden-layer sequencer.
// Provides the FSM state encoding, the default word widths and the counter
// width helpers used by the top level and the result collector.
// The default widths follow `dataWidth and `ROM_bitwidth when those macros
// are defined.
`ifndef dataWidth
`define dataWidth 16
`endif
`ifndef ROM_bitwidth
`define ROM_bitwidth 16
`endif

package elm_layer_sequencer_pkg;

    localparam int unsigned ELM_DATA_W = `dataWidth;
    localparam int unsigned ELM_OUT_W  = `ROM_bitwidth;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BCAST = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Counter wide enough to hold the bound itself, so counters never wrap.
    function automatic int unsigned cnt_w(input int unsigned bound);
        return $clog2(bound) + 1;
    endfunction

    // Index width for an array of n entries (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elm_result_collector.sv
// Collects one activation per neuron while the sequencer waits.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   active            high while the sequencer is in WAIT
//   clear             end of drain: forget captured mask and timeout count
//   nrn_outvalid      per-neuron outvalid pulses
//   nrn_out           packed activations, neuron i at [i*OUT_W +: OUT_W]
//   res_c             result buffer as it will be after this edge
//   all_done_c        every neuron captured, including this cycle's pulses
//   timeout_c         last allowed WAIT cycle passed without completion
module elm_result_collector
    import elm_layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = 32,
    parameter int unsigned OUT_W       = ELM_OUT_W,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         active,
    input  logic                         clear,
    input  logic [NUM_NEURONS-1:0]       nrn_outvalid,
    input  logic [NUM_NEURONS*OUT_W-1:0] nrn_out,
    output logic [NUM_NEURONS*OUT_W-1:0] res_c,
    output logic                         all_done_c,
    output logic                         timeout_c
);

    localparam int unsigned TW = cnt_w(TIMEOUT);

    logic [NUM_NEURONS-1:0]       captured;
    logic [NUM_NEURONS-1:0]       new_mask;
    logic [NUM_NEURONS-1:0]       cap_next;
    logic [TW-1:0]                tcnt;
    logic [NUM_NEURONS*OUT_W-1:0] res_buf;

    // First pulse per neuron wins; on timeout the missing slots read as zero.
    always_comb begin
        new_mask   = active ? (nrn_outvalid & ~captured) : '0;
        cap_next   = captured | new_mask;
        all_done_c = active && (&cap_next);
        timeout_c  = active && !(&cap_next) && (tcnt == TW'(TIMEOUT - 1));
        res_c      = res_buf;
        for (int i = 0; i < int'(NUM_NEURONS); i++) begin
            if (new_mask[i]) begin
                res_c[i*OUT_W +: OUT_W] = nrn_out[i*OUT_W +: OUT_W];
            end else if (timeout_c && !cap_next[i]) begin
                res_c[i*OUT_W +: OUT_W] = '0;
            end
        end
    end

    // Captured mask and saturating WAIT-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            captured <= '0;
            tcnt     <= '0;
        end else if (clear) begin
            captured <= '0;
            tcnt     <= '0;
        end else if (active) begin
            captured <= cap_next;
            if (tcnt != TW'(TIMEOUT - 1)) begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

    // Result storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        res_buf <= res_c;
    end

endmodule

// File: rtl/elm_layer_sequencer.sv
// Sequences one hidden layer of ELM neurons: buffers an input vector,
// broadcasts it to all neurons as one contiguous valid burst, collects each
// neuron's activation and streams the results downstream in neuron order.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   s_data, s_valid, s_ready         input vector stream
//   nrn_in, nrn_in_valid             broadcast word / valid to all neurons
//   nrn_outvalid, nrn_out            per-neuron result pulses and activations
//   m_data, m_valid, m_last, m_ready result stream, m_last on the last neuron
//   busy                             high in any state except LOAD
//   err_timeout                      sticky, set when WAIT times out
module elm_layer_sequencer
    import elm_layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 128,
    parameter int unsigned NUM_NEURONS = 32,
    parameter int unsigned DATA_W      = ELM_DATA_W,
    parameter int unsigned OUT_W       = ELM_OUT_W,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [DATA_W-1:0]            nrn_in,
    output logic                         nrn_in_valid,
    input  logic [NUM_NEURONS-1:0]       nrn_outvalid,
    input  logic [NUM_NEURONS*OUT_W-1:0] nrn_out,
    output logic [OUT_W-1:0]             m_data,
    output logic                         m_valid,
    output logic                         m_last,
    input  logic                         m_ready,
    output logic                         busy,
    output logic                         err_timeout
);

    localparam int unsigned WW = cnt_w(NUM_INPUTS);
    localparam int unsigned OW = cnt_w(NUM_NEURONS);
    localparam int unsigned IW = idx_w(NUM_INPUTS);

    state_t                       state;
    logic [WW-1:0]                wcnt;
    logic [WW-1:0]                rcnt;
    logic [OW-1:0]                ocnt;
    logic [OW-1:0]                ocnt_inc;
    logic [DATA_W-1:0]            in_buf [NUM_INPUTS];
    logic [DATA_W-1:0]            first_word_c;
    logic                         accept_c;
    logic                         wait_c;
    logic                         drain_done_c;
    logic                         all_done_c;
    logic                         timeout_c;
    logic [NUM_NEURONS*OUT_W-1:0] res_c;

    assign accept_c     = (state == ST_LOAD) && s_valid && s_ready;
    assign wait_c       = (state == ST_WAIT);
    assign drain_done_c = (state == ST_DRAIN) && m_valid && m_ready
                          && (ocnt == OW'(NUM_NEURONS - 1));
    assign ocnt_inc     = ocnt + OW'(1);
    // With a one-word vector the first word is the one being accepted now.
    assign first_word_c = (NUM_INPUTS == 1) ? s_data : in_buf[0];

    elm_result_collector #(
        .NUM_NEURONS (NUM_NEURONS),
        .OUT_W       (OUT_W),
        .TIMEOUT     (TIMEOUT)
    ) u_collector (
        .clk          (clk),
        .rst          (rst),
        .active       (wait_c),
        .clear        (drain_done_c),
        .nrn_outvalid (nrn_outvalid),
        .nrn_out      (nrn_out),
        .res_c        (res_c),
        .all_done_c   (all_done_c),
        .timeout_c    (timeout_c)
    );

    // Input vector buffer; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            in_buf[IW'(wcnt)] <= s_data;
        end
    end

    // Sequencer FSM with registered stream and neuron outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_LOAD;
            wcnt         <= '0;
            rcnt         <= '0;
            ocnt         <= '0;
            s_ready      <= 1'b1;
            nrn_in       <= '0;
            nrn_in_valid <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept_c) begin
                        if (wcnt == WW'(NUM_INPUTS - 1)) begin
                            // Word 0 goes out on the first BCAST cycle, so the burst has no bubble.
                            wcnt         <= '0;
                            s_ready      <= 1'b0;
                            nrn_in       <= first_word_c;
                            nrn_in_valid <= 1'b1;
                            rcnt         <= WW'(1);
                            busy         <= 1'b1;
                            state        <= ST_BCAST;
                        end else begin
                            wcnt <= wcnt + WW'(1);
                        end
                    end
                end
                ST_BCAST: begin
                    if (rcnt == WW'(NUM_INPUTS)) begin
                        // Falling edge of valid starts the neurons' bias add.
                        nrn_in_valid <= 1'b0;
                        nrn_in       <= '0;
                        rcnt         <= '0;
                        state        <= ST_WAIT;
                    end else begin
                        nrn_in <= in_buf[IW'(rcnt)];
                        rcnt   <= rcnt + WW'(1);
                    end
                end
                ST_WAIT: begin
                    if (all_done_c || timeout_c) begin
                        if (timeout_c) begin
                            err_timeout <= 1'b1;
                        end
                        // res_c already includes this cycle's captures.
                        m_valid <= 1'b1;
                        m_data  <= res_c[OUT_W-1:0];
                        m_last  <= (NUM_NEURONS == 1);
                        state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (m_valid && m_ready) begin
                        if (ocnt == OW'(NUM_NEURONS - 1)) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            ocnt    <= '0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_LOAD;
                        end else begin
                            ocnt    <= ocnt_inc;
                            m_data  <= res_c[32'(ocnt_inc)*OUT_W +: OUT_W];
                            m_last  <= (ocnt_inc == OW'(NUM_NEURONS - 1));
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// Directed self-checking bench for elm_layer_sequencer with a 4-word vector,
// 3 neurons and an 8-cycle WAIT timeout. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_elm_layer_sequencer;

    localparam int unsigned NI = 4;
    localparam int unsigned NN = 3;
    localparam int unsigned TO = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned OW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    s_data;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    nrn_in;
    logic             nrn_in_valid;
    logic [NN-1:0]    nrn_outvalid;
    logic [NN*OW-1:0] nrn_out;
    logic [OW-1:0]    m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic             busy;
    logic             err_timeout;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    elm_layer_sequencer #(
        .NUM_INPUTS  (NI),
        .NUM_NEURONS (NN),
        .DATA_W      (DW),
        .OUT_W       (OW),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .nrn_in       (nrn_in),
        .nrn_in_valid (nrn_in_valid),
        .nrn_outvalid (nrn_outvalid),
        .nrn_out      (nrn_out),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .busy         (busy),
        .err_timeout  (err_timeout)
    );

    // Feed words b..b+3 and return on the first WAIT negedge.
    task automatic drive_vector(input int b);
        for (int i = 0; i < int'(NI); i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = DW'(b + i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (NI) @(negedge clk);
    endtask

    // Accept up to 'want' results with m_ready high; bounded wait.
    task automatic drain_collect(input int want, output logic [NN*OW-1:0] dv,
                                 output logic [NN-1:0] lv, output int n);
        n = 0;
        dv = '0;
        lv = '0;
        m_ready = 1'b1;
        for (int c = 0; c < 40 && n < want; c++) begin
            if (m_valid === 1'b1) begin
                dv[n*OW +: OW] = m_data;
                lv[n] = m_last;
                n++;
            end
            if (n < want) @(negedge clk);
        end
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", s_ready); else passed++;
        checks++; if (nrn_in_valid !== 1'b0) $display("FAIL reset_nrn_in_valid got %b want 0", nrn_in_valid); else passed++;
        checks++; if (nrn_in !== 16'h0) $display("FAIL reset_nrn_in got %h want 0", nrn_in); else passed++;
        checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passed++;
        checks++; if (m_last !== 1'b0) $display("FAIL reset_m_last got %b want 0", m_last); else passed++;
        checks++; if (m_data !== 16'h0) $display("FAIL reset_m_data got %h want 0", m_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err got %b want 0", err_timeout); else passed++;
    endtask

    task automatic test_bcast();
        logic [NN*OW-1:0] dv;
        logic [NN-1:0]    lv;
        int               n;
        for (int i = 0; i < int'(NI); i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = DW'(i + 1);
        end
        for (int k = 0; k < int'(NI); k++) begin
            @(negedge clk);
            s_valid = 1'b0;
            checks++;
            if (nrn_in_valid !== 1'b1 || nrn_in !== DW'(k + 1) || s_ready !== 1'b0)
                $display("FAIL bcast_word%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                         k, nrn_in_valid, nrn_in, s_ready, DW'(k + 1));
            else passed++;
        end
        @(negedge clk);
        checks++; if (nrn_in_valid !== 1'b0) $display("FAIL bcast_end_valid got %b want 0", nrn_in_valid); else passed++;
        nrn_outvalid = 3'b111;
        nrn_out = {16'h0003, 16'h0002, 16'h0001};
        @(negedge clk);
        nrn_outvalid = '0;
        drain_collect(3, dv, lv, n);
    endtask

    task automatic test_order();
        logic [NN*OW-1:0] dv;
        logic [NN-1:0]    lv;
        int               n;
        drive_vector(5);
        checks++; if (s_ready !== 1'b0 || busy !== 1'b1) $display("FAIL wait_flags got rdy=%b busy=%b want 0 1", s_ready, busy); else passed++;
        nrn_outvalid = 3'b100; nrn_out = {16'h0030, 16'h0000, 16'h0000};
        @(negedge clk);
        nrn_outvalid = 3'b001; nrn_out = {16'h0000, 16'h0000, 16'h0010};
        @(negedge clk);
        nrn_outvalid = 3'b010; nrn_out = {16'h0000, 16'h0020, 16'h0000};
        @(negedge clk);
        nrn_outvalid = '0;
        checks++; if (s_ready !== 1'b0) $display("FAIL drain_s_ready got %b want 0", s_ready); else passed++;
        drain_collect(3, dv, lv, n);
        checks++; if (n != 3) $display("FAIL order_count got %0d want 3", n); else passed++;
        checks++; if (dv !== 48'h0030_0020_0010) $display("FAIL order_data got %h want 003000200010", dv); else passed++;
        checks++; if (lv !== 3'b100) $display("FAIL order_last got %b want 100", lv); else passed++;
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL order_back_to_load got rdy=%b busy=%b mv=%b want 1 0 0", s_ready, busy, m_valid);
        else passed++;
    endtask

    task automatic test_same_cycle();
        logic [NN*OW-1:0] dv;
        logic [NN-1:0]    lv;
        int               n;
        drive_vector(9);
        nrn_outvalid = 3'b111; nrn_out = {16'h0033, 16'h0022, 16'h0011};
        @(negedge clk);
        nrn_outvalid = '0;
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0011 || m_last !== 1'b0)
            $display("FAIL same_cycle_first got v=%b d=%h l=%b want 1 0011 0", m_valid, m_data, m_last);
        else passed++;
        drain_collect(3, dv, lv, n);
        checks++; if (dv !== 48'h0033_0022_0011 || n != 3) $display("FAIL same_cycle_data got %h n=%0d want 003300220011 n=3", dv, n); else passed++;
        checks++; if (lv !== 3'b100) $display("FAIL same_cycle_last got %b want 100", lv); else passed++;
    endtask

    task automatic test_duplicate();
        logic [NN*OW-1:0] dv;
        logic [NN-1:0]    lv;
        int               n;
        drive_vector(13);
        nrn_outvalid = 3'b001; nrn_out = {16'h0000, 16'h0000, 16'h0010};
        @(negedge clk);
        nrn_outvalid = 3'b001; nrn_out = {16'h0000, 16'h0000, 16'h00FF};
        @(negedge clk);
        nrn_outvalid = 3'b111; nrn_out = {16'h0030, 16'h0020, 16'h00EE};
        @(negedge clk);
        nrn_outvalid = '0;
        drain_collect(3, dv, lv, n);
        checks++; if (dv !== 48'h0030_0020_0010 || n != 3) $display("FAIL duplicate_data got %h n=%0d want 003000200010 n=3", dv, n); else passed++;
    endtask

    task automatic test_timeout();
        logic [NN*OW-1:0] dv;
        logic [NN-1:0]    lv;
        int               n;
        drive_vector(17);
        nrn_outvalid = 3'b101; nrn_out = {16'h0030, 16'h0077, 16'h0010};
        @(negedge clk);
        nrn_outvalid = '0;
        repeat (6) @(negedge clk);
        checks++; if (err_timeout !== 1'b0 || m_valid !== 1'b0)
            $display("FAIL timeout_early got err=%b mv=%b want 0 0", err_timeout, m_valid);
        else passed++;
        @(negedge clk);
        checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_err got %b want 1", err_timeout); else passed++;
        drain_collect(3, dv, lv, n);
        checks++; if (dv !== 48'h0030_0000_0010 || n != 3) $display("FAIL timeout_data got %h n=%0d want 003000000010 n=3", dv, n); else passed++;
        checks++; if (lv !== 3'b100) $display("FAIL timeout_last got %b want 100", lv); else passed++;
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b1)
            $display("FAIL timeout_to_load got rdy=%b busy=%b err=%b want 1 0 1", s_ready, busy, err_timeout);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [NN*OW-1:0] dv;
        logic [NN-1:0]    lv;
        int               n;
        drive_vector(21);
        nrn_outvalid = 3'b111; nrn_out = {16'h00A3, 16'h00A2, 16'h00A1};
        m_ready = 1'b0;
        @(negedge clk);
        nrn_outvalid = '0;
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h00A1) $display("FAIL bp_first got v=%b d=%h want 1 00a1", m_valid, m_data); else passed++;
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_data !== 16'h00A2 || m_last !== 1'b0)
                $display("FAIL bp_hold%0d got v=%b d=%h l=%b want 1 00a2 0", c, m_valid, m_data, m_last);
            else passed++;
        end
        drain_collect(2, dv, lv, n);
        checks++; if (dv[31:0] !== 32'h00A3_00A2 || lv[1:0] !== 2'b10 || n != 2)
            $display("FAIL bp_tail got d=%h l=%b n=%0d want 00a300a2 10 2", dv[31:0], lv[1:0], n);
        else passed++;
        checks++; if (err_timeout !== 1'b1) $display("FAIL err_sticky got %b want 1", err_timeout); else passed++;
    endtask

    task automatic test_reset_bcast();
        for (int i = 0; i < int'(NI); i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = DW'(40 + i);
        end
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (nrn_in_valid !== 1'b1 || busy !== 1'b1) $display("FAIL rst_pre got v=%b busy=%b want 1 1", nrn_in_valid, busy); else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (nrn_in_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rst_bcast got v=%b rdy=%b busy=%b want 0 1 0", nrn_in_valid, s_ready, busy);
        else passed++;
        checks++; if (err_timeout !== 1'b0) $display("FAIL rst_err_clear got %b want 0", err_timeout); else passed++;
    endtask

    initial begin
        rst          = 1'b1;
        s_data       = '0;
        s_valid      = 1'b0;
        nrn_outvalid = '0;
        nrn_out      = '0;
        m_ready      = 1'b0;
        test_reset();
        test_bcast();
        test_order();
        test_same_cycle();
        test_duplicate();
        test_timeout();
        test_backpressure();
        test_reset_bcast();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
